// File: rtl/arb_pkt_mux.sv
// arb_pkt_mux: packet stream mux that holds one arbiter grant per packet, registered output. Rev 1.0
// Define ARB_PKT_MUX_CHECK_EN to add a sticky err output and integration assertions.
`default_nettype none

module arb_pkt_mux #(
   parameter int WIDTH  = 16,
   parameter int DWIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        in_valid,
   output logic [WIDTH-1:0]        in_ready,
   input  logic [WIDTH*DWIDTH-1:0] in_data,
   input  logic [WIDTH-1:0]        in_last,
   output logic [WIDTH-1:0]        arb_req,
   input  logic [WIDTH-1:0]        arb_grant,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DWIDTH-1:0]       out_data,
   output logic                    out_last,
   output logic [WIDTH-1:0]        out_src
`ifdef ARB_PKT_MUX_CHECK_EN
   ,
   output logic                    err
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   sel;
   logic               load_en;
   logic [WIDTH-1:0]   g;
   logic [WIDTH-1:0]   acc_vec;
   logic               acc;
   logic               acc_last;
   logic [DWIDTH-1:0]  sel_data;

   // Requests reach the arbiter only when a packet may start, so one credit is spent per packet.
   always_comb begin
      load_en  = !out_valid || out_ready;
      arb_req  = '0;
      in_ready = '0;
      g        = '0;
      if (rst_n) begin
         if (state == IDLE) begin
            if (load_en) begin
               arb_req = in_valid;
            end
            g        = arb_grant & arb_req;
            in_ready = g;
         end else if (load_en) begin
            in_ready = sel;
         end
      end
   end

   always_comb begin
      acc_vec  = in_valid & in_ready;
      acc      = |acc_vec;
      acc_last = |(in_last & acc_vec);
      sel_data = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sel_data = sel_data | (in_data[DWIDTH*i +: DWIDTH] & {DWIDTH{acc_vec[i]}});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (acc && !acc_last) begin
                  state <= BUSY;
                  sel   <= g;
               end
            end
            BUSY: begin
               if (acc && acc_last) begin
                  state <= IDLE;
                  sel   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               sel   <= '0;
            end
         endcase

         if (acc) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= acc_last;
            out_src   <= acc_vec;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef ARB_PKT_MUX_CHECK_EN
   logic multi_g;
   logic sel_vld;
   logic sel_vld_q;
   logic drop;

   assign multi_g = (state == IDLE) && ((g & (g - WIDTH'(1))) != '0);
   assign sel_vld = |(in_valid & sel);
   assign drop    = (state == BUSY) && sel_vld_q && !sel_vld;

   // sel_vld_q tracks whether the held channel was presenting a beat while its packet is still open.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err       <= 1'b0;
         sel_vld_q <= 1'b0;
      end else begin
         sel_vld_q <= (state == IDLE) ? (acc && !acc_last) : (sel_vld && !(acc && acc_last));
         if (multi_g || drop) begin
            err <= 1'b1;
         end
      end
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) !multi_g);
   a_no_valid_drop: assert property (@(posedge clk) disable iff (!rst_n) !drop);
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_pkt_mux.sv
// tb_arb_pkt_mux: directed bench for arb_pkt_mux, WIDTH=4, with a round-robin arbiter model.
`default_nettype none

module tb_arb_pkt_mux;

   localparam int W  = 4;
   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic [W-1:0]    in_valid;
   logic [W-1:0]    in_ready;
   logic [W*DW-1:0] in_data;
   logic [W-1:0]    in_last;
   logic [W-1:0]    arb_req;
   logic [W-1:0]    arb_grant;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [W-1:0]    out_src;
`ifdef ARB_PKT_MUX_CHECK_EN
   logic            err;
`endif

   arb_pkt_mux #(.WIDTH(W), .DWIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .arb_req   (arb_req),
      .arb_grant (arb_grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src)
`ifdef ARB_PKT_MUX_CHECK_EN
      ,
      .err       (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int       vectors    = 0;
   int       miscompares = 0;
   int       rem[W];
   int       seq[W];
   int       ptr;
   bit       refill;
   bit       force_g;
   logic [W-1:0] force_val;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rr(input logic [W-1:0] req, input int p);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < W; k++) begin
         int idx;
         idx = (p + k) % W;
         if (r == '0 && req[idx]) r[idx] = 1'b1;
      end
      return r;
   endfunction

   task automatic drive();
      for (int i = 0; i < W; i++) begin
         in_valid[i] = (rem[i] > 0);
         in_last[i]  = (rem[i] == 1);
         in_data[DW*i +: DW] = 32'hD000_0000 | (32'(i) << 8) | 32'(seq[i]);
      end
   endtask

   task automatic settle();
      #1;
      arb_grant = force_g ? force_val : rr(arb_req, ptr);
      #1;
   endtask

   task automatic step();
      logic [W-1:0] a;
      logic [W-1:0] gn;
      a  = in_valid & in_ready;
      gn = arb_grant & arb_req;
      @(posedge clk);
      #1;
      for (int i = 0; i < W; i++) if (gn[i]) ptr = (i + 1) % W;
      for (int i = 0; i < W; i++) begin
         if (a[i]) begin
            rem[i]--;
            seq[i]++;
            if (refill && rem[i] == 0) rem[i] = 1;
         end
      end
      drive();
      settle();
   endtask

   logic [W-1:0]  exp_src[6];
   logic [DW-1:0] exp_dat[6];

   initial begin
      for (int i = 0; i < W; i++) begin
         rem[i] = 0;
         seq[i] = 0;
      end
      ptr       = 0;
      refill    = 0;
      force_g   = 0;
      force_val = '0;
      arb_grant = '0;
      out_ready = 1'b1;
      rst_n     = 1'b0;

      // Reset: outputs cleared, combinational handshakes forced low even with valids up.
      rem[0] = 3;
      rem[2] = 3;
      drive();
      settle();
      step();
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_arb_req", arb_req, 0);
      chk("rst_in_ready", in_ready, 0);

      // Two 3-beat packets on channels 0 and 2.
      rst_n = 1'b1;
      settle();
      chk("t1_req_start0", arb_req, 4'b0101);
      chk("t1_rdy_start0", in_ready, 4'b0001);
      step();
      chk("t1_b0_valid", out_valid, 1);
      chk("t1_b0_src", out_src, 4'b0001);
      chk("t1_b0_data", out_data, 32'hD000_0000);
      chk("t1_b0_last", out_last, 0);
      chk("t1_b0_req", arb_req, 0);
      chk("t1_b0_rdy", in_ready, 4'b0001);
      step();
      chk("t1_b1_data", out_data, 32'hD000_0001);
      chk("t1_b1_last", out_last, 0);
      chk("t1_b1_req", arb_req, 0);
      step();
      chk("t1_b2_data", out_data, 32'hD000_0002);
      chk("t1_b2_last", out_last, 1);
      chk("t1_b2_src", out_src, 4'b0001);
      chk("t1_req_start2", arb_req, 4'b0100);
      chk("t1_rdy_start2", in_ready, 4'b0100);
      step();
      chk("t1_c0_src", out_src, 4'b0100);
      chk("t1_c0_data", out_data, 32'hD000_0200);
      chk("t1_c0_last", out_last, 0);
      chk("t1_c0_req", arb_req, 0);
      step();
      chk("t1_c1_data", out_data, 32'hD000_0201);
      chk("t1_c1_last", out_last, 0);
      step();
      chk("t1_c2_data", out_data, 32'hD000_0202);
      chk("t1_c2_last", out_last, 1);
      chk("t1_c2_src", out_src, 4'b0100);
      chk("t1_idle_req", arb_req, 0);

      // Continuous single-beat packets on all channels; arbiter pointer starts at channel 3.
      exp_src[0] = 4'b1000; exp_dat[0] = 32'hD000_0300;
      exp_src[1] = 4'b0001; exp_dat[1] = 32'hD000_0003;
      exp_src[2] = 4'b0010; exp_dat[2] = 32'hD000_0100;
      exp_src[3] = 4'b0100; exp_dat[3] = 32'hD000_0203;
      exp_src[4] = 4'b1000; exp_dat[4] = 32'hD000_0301;
      exp_src[5] = 4'b0001; exp_dat[5] = 32'hD000_0004;
      refill = 1;
      for (int i = 0; i < W; i++) rem[i] = 1;
      drive();
      settle();
      for (int k = 0; k < 6; k++) begin
         step();
         chk("t2_valid", out_valid, 1);
         chk("t2_src", out_src, exp_src[k]);
         chk("t2_data", out_data, exp_dat[k]);
         chk("t2_last", out_last, 1);
      end
      refill = 0;
      repeat (4) step();
      chk("t2_drain_src", out_src, 4'b0001);
      chk("t2_drain_data", out_data, 32'hD000_0005);

      // Channel 1 mid-packet blocks channel 3 until its last beat leaves.
      rem[1] = 4;
      drive();
      settle();
      chk("t3_req_start", arb_req, 4'b0010);
      chk("t3_rdy_start", in_ready, 4'b0010);
      step();
      chk("t3_b0_data", out_data, 32'hD000_0102);
      step();
      chk("t3_b1_data", out_data, 32'hD000_0103);
      rem[3] = 2;
      drive();
      settle();
      chk("t3_block_req", arb_req, 0);
      chk("t3_block_rdy", in_ready, 4'b0010);
      step();
      chk("t3_b2_data", out_data, 32'hD000_0104);
      chk("t3_b2_req", arb_req, 0);
      chk("t3_b2_rdy", in_ready, 4'b0010);
      step();
      chk("t3_b3_data", out_data, 32'hD000_0105);
      chk("t3_b3_last", out_last, 1);
      chk("t3_ch3_req", arb_req, 4'b1000);
      chk("t3_ch3_rdy", in_ready, 4'b1000);
      step();
      chk("t3_ch3_src", out_src, 4'b1000);
      chk("t3_ch3_data", out_data, 32'hD000_0303);
      chk("t3_ch3_last", out_last, 0);

      // Backpressure for 5 cycles holds the output beat.
      out_ready = 1'b0;
      settle();
      chk("t4_bp_rdy", in_ready, 0);
      chk("t4_bp_req", arb_req, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_hold_data", out_data, 32'hD000_0303);
         chk("t4_hold_src", out_src, 4'b1000);
         chk("t4_hold_last", out_last, 0);
         chk("t4_hold_rdy", in_ready, 0);
         chk("t4_hold_req", arb_req, 0);
      end
      out_ready = 1'b1;
      settle();
      chk("t4_resume_rdy", in_ready, 4'b1000);
      step();
      chk("t4_next_valid", out_valid, 1);
      chk("t4_next_data", out_data, 32'hD000_0304);
      chk("t4_next_last", out_last, 1);
      step();
      chk("t4_empty_valid", out_valid, 0);
      chk("t4_empty_data", out_data, 32'hD000_0304);

      // Reset during beat 2 of a 4-beat packet on channel 0.
      rem[0] = 4;
      drive();
      settle();
      chk("t5_req_start", arb_req, 4'b0001);
      step();
      chk("t5_b0_data", out_data, 32'hD000_0006);
      step();
      chk("t5_b1_data", out_data, 32'hD000_0007);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_src", out_src, 0);
      chk("t5_rst_rdy", in_ready, 0);
      chk("t5_rst_req", arb_req, 0);
      step();
      rem[0] = 2;
      rst_n  = 1'b1;
      drive();
      settle();
      chk("t5_restart_req", arb_req, 4'b0001);
      chk("t5_restart_rdy", in_ready, 4'b0001);
      step();
      chk("t5_r0_src", out_src, 4'b0001);
      chk("t5_r0_data", out_data, 32'hD000_0008);
      chk("t5_r0_last", out_last, 0);
      chk("t5_r0_req", arb_req, 0);
      step();
      chk("t5_r1_data", out_data, 32'hD000_0009);
      chk("t5_r1_last", out_last, 1);

`ifdef ARB_PKT_MUX_CHECK_EN
      // Non-one-hot grant sets the sticky error flag.
      force_g   = 1;
      force_val = 4'b0011;
      rem[0]    = 1;
      rem[1]    = 1;
      drive();
      settle();
      chk("t6_req", arb_req, 4'b0011);
      chk("t6_err_pre", err, 0);
      step();
      chk("t6_err_set", err, 1);
      chk("t6_or_data", out_data, 32'hD000_010E);
      force_g = 0;
      step();
      step();
      chk("t6_err_sticky", err, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_err_clr", err, 0);
      rst_n = 1'b1;
      settle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/arb_pkt_mux.md
Name: arb_pkt_mux

Overview:
- Packet-level stream multiplexer that sits directly downstream of the team's combinational arbiters (round-robin / weighted round-robin).
- Presents per-channel requests to the arbiter only when a new packet may start, so the arbiter spends exactly one credit per packet.
- Latches the resulting one-hot grant and holds it until that packet's last beat is accepted.
- Forwards beats through one registered output stage with valid/ready flow control.

Parameters:
- WIDTH, 16, number of input channels; must match the arbiter's WIDTH.
- DWIDTH, 32, data bits per beat.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  WIDTH  per-channel beat valid.
- in_ready  out  WIDTH  per-channel beat accept.
- in_data  in  WIDTH*DWIDTH  channel i occupies bits [DWIDTH*i+DWIDTH-1 : DWIDTH*i].
- in_last  in  WIDTH  per-channel end-of-packet flag.
- arb_req  out  WIDTH  request vector driven to the arbiter's req input.
- arb_grant  in  WIDTH  one-hot grant returned combinationally by the arbiter in the same cycle.
- out_valid  out  1  registered output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DWIDTH  registered output data.
- out_last  out  1  registered end-of-packet.
- out_src  out  WIDTH  one-hot source channel of the current output beat.

Behaviour:
- Reset: clk and rst_n as above; async assert, sync deassert is the integrator's responsibility.
  - Reset values: state=IDLE, sel=0, out_valid=0, out_data=0, out_last=0, out_src=0.
  - Combinational outputs resolve to in_ready=0 and arb_req=0 while in reset.
- Definitions:
  - load_en = !out_valid || out_ready (output register can take a beat this cycle).
  - acc = any bit of (in_valid & in_ready).
- State IDLE:
  - arb_req = load_en ? in_valid : 0.
  - g = arb_grant & arb_req.
  - in_ready = g.
  - If g != 0, the granted beat is accepted this cycle (zero-bubble packet start).
  - If that beat has in_last=1, stay IDLE. Single-beat packets therefore sustain one packet per cycle.
  - Otherwise sel <= g and state <= BUSY.
  - If g == 0, nothing is accepted and state is unchanged.
- State BUSY:
  - arb_req = 0, so no arbiter credit is consumed mid-packet.
  - in_ready = sel when load_en, else 0.
  - A beat is accepted when in_valid & sel is nonzero and load_en=1.
  - Accepting a beat with in_last=1 sets state <= IDLE and sel <= 0.
  - Other channels' valids are ignored; their in_ready is 0.
- Output register:
  - On acc: out_valid<=1; out_data<=selected in_data; out_last<=selected in_last; out_src<=accepted channel one-hot.
  - Else if out_ready: out_valid<=0; data, last and src hold their previous values.
  - Latency: input beat to out_valid is 1 cycle.
  - Throughput: 1 beat/cycle while out_ready=1.
- Data select: AND-OR of in_data slices with the one-hot accept vector (no priority encoder).
- Grant with a bit outside arb_req is masked off by g. A grant that is not one-hot after masking is an integration error; data is then the OR of the selected slices.
- in_valid dropping mid-packet in BUSY: the block waits with sel held and no timeout.
- Backpressure (out_ready=0 with out_valid=1): in_ready=0 and arb_req=0. The held output is stable and no arbiter credit is consumed.
- Reset mid-packet: the partial packet is abandoned. The next beat from any channel is treated as a packet start.
- out_valid must never change from 1 to 0 without out_ready=1, and out_data/out_last/out_src must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: ARB_PKT_MUX_CHECK_EN.
- When defined:
  - Adds port err (out, 1): a sticky error flag, cleared only by rst_n.
  - err sets the cycle after either of these occurs: in IDLE, (arb_grant & arb_req) is nonzero and not one-hot; in BUSY, in_valid & sel falls from 1 to 0 before the last beat is accepted.
  - Also adds simulation assertions on the same conditions.
- When undefined: no err port, no check logic; behaviour otherwise identical.

Test Plan:
- WIDTH=4 behind a WRR arbiter, weights all 1. Channels 0 and 2 each send 3-beat packets, out_ready=1.
  - out_src = 0001 x3 then 0100 x3.
  - out_last high only on the 3rd beat of each packet.
  - arb_req nonzero only on packet-start cycles.
- All four channels send single-beat packets continuously with out_ready=1.
  - One beat per cycle; out_src rotates 0001,0010,0100,1000.
  - out_last=1 on every beat.
- Channel 1 is mid-packet (2 of 4 beats) and channel 3 raises valid.
  - Channel 3's in_ready stays 0 until channel 1's last beat leaves; arb_req stays 0 throughout.
- out_ready held 0 for 5 cycles with out_valid=1.
  - out_data/out_last/out_src are stable, in_ready=0, arb_req=0.
  - The beat is consumed in the first cycle after out_ready returns to 1.
- rst_n asserted on beat 2 of a 4-beat packet on channel 0.
  - out_valid=0 immediately; state returns to IDLE.
  - After release, channel 0's next beat is arbitrated as a new packet start.
- With ARB_PKT_MUX_CHECK_EN defined, arb_grant forced to 0011 while arb_req=0011.
  - err=1 the next cycle and stays 1 until rst_n.
